// File: rtl/async_fifo_rd_stream_if.sv
// Read-side bundle: async_fifo pop port plus the outgoing valid/ready stream.
// master = the drain stage, slave = the FIFO/downstream side.
interface async_fifo_rd_stream_if #(
  parameter int DSIZE = 32
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data, m_last
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, m_last
  );
endinterface

// File: rtl/async_fifo_rd_stream.sv
// Drains async_fifo into a packetised valid/ready stream via a small skid buffer.
// rinc depends only on registered state and rempty, never on m_ready.
module async_fifo_rd_stream #(
  parameter int    DSIZE       = 32,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    PKT_LEN     = 16,
  parameter int    CNT_W       = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  async_fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam bit FT    = (FALLTHROUGH == "TRUE");
  localparam int DEPTH = FT ? 2 : 3;
  localparam int PW    = $clog2(DEPTH);
  localparam int BW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [1:0]       r_occ;
  logic             r_infl;
  logic [BW-1:0]    r_beat;
  logic [CNT_W-1:0] r_cnt;

  logic       w_rinc;
  logic       w_wr;
  logic       w_valid;
  logic       w_xfer;
  logic       w_beat_end;
  logic [2:0] w_used;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reserve a slot for every pop still in flight so a capture never overflows.
  assign w_used     = {1'b0, r_occ} + {2'b00, r_infl};
  assign w_rinc     = !rrst && !bus.rempty && (w_used < 3'(DEPTH));
  assign w_wr       = FT ? w_rinc : r_infl;
  assign w_valid    = (r_occ != 2'd0);
  assign w_xfer     = w_valid && bus.m_ready;
  assign w_beat_end = (r_beat == BW'(PKT_LEN - 1));

  assign bus.rinc    = w_rinc;
  assign bus.m_valid = w_valid;
  assign bus.m_data  = r_mem[r_rptr];
  assign bus.m_last  = w_valid && w_beat_end;
  assign word_cnt    = r_cnt;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_infl <= 1'b0;
      r_beat <= '0;
      r_cnt  <= '0;
    end else begin
      r_infl <= FT ? 1'b0 : w_rinc;
      if (w_wr) begin
        r_mem[r_wptr] <= bus.rdata;
        r_wptr        <= f_nxt(r_wptr);
      end
      if (w_xfer) begin
        r_rptr <= f_nxt(r_rptr);
        r_beat <= w_beat_end ? '0 : r_beat + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      unique case ({w_wr, w_xfer})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: fall-through and registered-read FIFO models,
// directed vectors, backpressure, random traffic and mid-packet reset.
module tb_async_fifo_rd_stream;

  logic rclk = 1'b0;
  logic rrst = 1'b0;
  always #5 rclk = ~rclk;

  async_fifo_rd_stream_if #(.DSIZE(32)) f0();
  async_fifo_rd_stream_if #(.DSIZE(32)) f1();

  logic [15:0] wc0;
  logic [3:0]  wc1;

  async_fifo_rd_stream #(
    .DSIZE(32), .FALLTHROUGH("TRUE"), .PKT_LEN(4), .CNT_W(16)
  ) u0 (
    .rclk(rclk), .rrst(rrst), .bus(f0.master), .word_cnt(wc0)
  );

  async_fifo_rd_stream #(
    .DSIZE(32), .FALLTHROUGH("FALSE"), .PKT_LEN(16), .CNT_W(4)
  ) u1 (
    .rclk(rclk), .rrst(rrst), .bus(f1.master), .word_cnt(wc1)
  );

  logic [31:0] fm0 [2048];
  logic [31:0] fm1 [2048];
  int h0 = 0, t0 = 0, h1 = 0, t1 = 0;
  logic gap0 = 1'b0, gap1 = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b0;
  logic [31:0] rq1 = '0;

  assign f0.rempty  = (h0 == t0) || gap0;
  assign f0.rdata   = fm0[h0[10:0]];
  assign f0.m_ready = rdy0;
  assign f1.rempty  = (h1 == t1) || gap1;
  assign f1.rdata   = rq1;
  assign f1.m_ready = rdy1;

  always @(posedge rclk) begin
    if (f0.rinc && !f0.rempty) h0 <= h0 + 1;
    if (f1.rinc && !f1.rempty) begin
      rq1 <= fm1[h1[10:0]];
      h1  <= h1 + 1;
    end
  end

  logic [31:0] lg0_d [2048];
  logic        lg0_l [2048];
  int          lg0_c [2048];
  logic [31:0] lg1_d [2048];
  logic        lg1_l [2048];
  int          lg1_c [2048];
  int n0 = 0, n1 = 0, v0 = 0, v1 = 0, cyc = 0;

  always @(posedge rclk) cyc <= cyc + 1;

  always @(negedge rclk) begin
    if (!rrst && f0.m_valid && f0.m_ready) begin
      lg0_d[n0] <= f0.m_data;
      lg0_l[n0] <= f0.m_last;
      lg0_c[n0] <= cyc;
      n0 <= n0 + 1;
    end
    if (!rrst && f1.m_valid && f1.m_ready) begin
      lg1_d[n1] <= f1.m_data;
      lg1_l[n1] <= f1.m_last;
      lg1_c[n1] <= cyc;
      n1 <= n1 + 1;
    end
    if (f0.rinc && f0.rempty) v0 <= v0 + 1;
    if (f1.rinc && f1.rempty) v1 <= v1 + 1;
  end

  typedef struct {
    logic [31:0] d;
    logic        l;
  } vec_t;
  vec_t t3 [20];

  int ntests = 0;
  int nfail  = 0;
  int b0, b1, hp0, hp1;
  logic [31:0] sd0, sd1;
  logic        sl0, sl1;

  task automatic chk(input string nm, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    steps(2);
    rrst = 1'b0;
    step();
  endtask

  task automatic push0(input logic [31:0] d);
    fm0[t0[10:0]] = d;
    t0 = t0 + 1;
  endtask

  task automatic push1(input logic [31:0] d);
    fm1[t1[10:0]] = d;
    t1 = t1 + 1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_rinc0"}, f0.rinc, 0);
    chk({nm, "_valid0"}, f0.m_valid, 0);
    chk({nm, "_last0"}, f0.m_last, 0);
    chk({nm, "_data0"}, f0.m_data, 0);
    chk({nm, "_cnt0"}, wc0, 0);
    chk({nm, "_rinc1"}, f1.rinc, 0);
    chk({nm, "_valid1"}, f1.m_valid, 0);
    chk({nm, "_last1"}, f1.m_last, 0);
    chk({nm, "_cnt1"}, wc1, 0);
  endtask

  initial begin
    t3 = '{
      '{32'd0, 1'b0},  '{32'd1, 1'b0},  '{32'd2, 1'b0},  '{32'd3, 1'b1},
      '{32'd4, 1'b0},  '{32'd5, 1'b0},  '{32'd6, 1'b0},  '{32'd7, 1'b1},
      '{32'd8, 1'b0},  '{32'd9, 1'b0},  '{32'd10, 1'b0}, '{32'd11, 1'b1},
      '{32'd12, 1'b0}, '{32'd13, 1'b0}, '{32'd14, 1'b0}, '{32'd15, 1'b1},
      '{32'd16, 1'b0}, '{32'd17, 1'b0}, '{32'd18, 1'b0}, '{32'd19, 1'b1}
    };

    // reset state, then 20 idle cycles with the FIFO empty
    #1 rrst = 1'b1;
    steps(2);
    @(negedge rclk);
    chk_idle("t1_rst");
    rrst = 1'b0;
    steps(20);
    @(negedge rclk);
    chk_idle("t1_hold");

    // single word: fall-through lands one edge earlier than registered read
    step();
    b0 = n0;
    b1 = n1;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    push0(32'hA);
    push1(32'hA);
    @(negedge rclk);
    chk("t2_n0_valid0", f0.m_valid, 0);
    chk("t2_n0_rinc0", f0.rinc, 1);
    @(negedge rclk);
    chk("t2_n1_valid0", f0.m_valid, 1);
    chk("t2_n1_data0", f0.m_data, 32'hA);
    chk("t2_n1_valid1", f1.m_valid, 0);
    @(negedge rclk);
    chk("t2_n2_valid0", f0.m_valid, 0);
    chk("t2_n2_cnt0", wc0, 1);
    chk("t2_n2_valid1", f1.m_valid, 1);
    chk("t2_n2_data1", f1.m_data, 32'hA);
    chk("t2_n2_last1", f1.m_last, 0);
    @(negedge rclk);
    chk("t2_n3_cnt1", wc1, 1);
    step();
    chk("t2_num0", n0 - b0, 1);
    chk("t2_log_d0", lg0_d[b0], 32'hA);
    chk("t2_log_l0", lg0_l[b0], 0);
    chk("t2_num1", n1 - b1, 1);
    chk("t2_log_l1", lg1_l[b1], 0);

    // 20-word burst at full rate, packets of 4 on u0
    do_reset();
    b0 = n0;
    b1 = n1;
    for (int i = 0; i < 20; i++) begin
      push0(32'(i));
      push1(32'(i));
    end
    steps(40);
    chk("t3_num0", n0 - b0, 20);
    chk("t3_num1", n1 - b1, 20);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t3_d0_%0d", i), lg0_d[b0 + i], t3[i].d);
      chk($sformatf("t3_l0_%0d", i), lg0_l[b0 + i], t3[i].l);
      chk($sformatf("t3_gap0_%0d", i), lg0_c[b0 + i] - lg0_c[b0], i);
      chk($sformatf("t3_d1_%0d", i), lg1_d[b1 + i], t3[i].d);
      chk($sformatf("t3_l1_%0d", i), lg1_l[b1 + i], (i == 15) ? 1 : 0);
      chk($sformatf("t3_gap1_%0d", i), lg1_c[b1 + i] - lg1_c[b1], i);
    end
    chk("t3_cnt0", wc0, 20);
    chk("t3_cnt1", wc1, 4);

    // backpressure: 10-cycle stall mid-stream
    do_reset();
    b0 = n0;
    b1 = n1;
    for (int i = 0; i < 12; i++) begin
      push0(32'(300 + i));
      push1(32'(300 + i));
    end
    steps(4);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    @(negedge rclk);
    sd0 = f0.m_data;
    sl0 = f0.m_last;
    sd1 = f1.m_data;
    sl1 = f1.m_last;
    repeat (10) begin
      @(negedge rclk);
      chk("t4_hold_v0", f0.m_valid, 1);
      chk("t4_hold_d0", f0.m_data, sd0);
      chk("t4_hold_l0", f0.m_last, sl0);
      chk("t4_hold_v1", f1.m_valid, 1);
      chk("t4_hold_d1", f1.m_data, sd1);
      chk("t4_hold_l1", f1.m_last, sl1);
    end
    chk("t4_full_rinc0", f0.rinc, 0);
    chk("t4_full_rinc1", f1.rinc, 0);
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    for (int k = 0; k < 100 && (n0 - b0 < 12 || n1 - b1 < 12); k++) step();
    chk("t4_num0", n0 - b0, 12);
    chk("t4_num1", n1 - b1, 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t4_d0_%0d", i), lg0_d[b0 + i], 300 + i);
      chk($sformatf("t4_d1_%0d", i), lg1_d[b1 + i], 300 + i);
    end

    // random ready and empty gaps, 1000 words each
    do_reset();
    b0 = n0;
    b1 = n1;
    hp0 = t0;
    hp1 = t1;
    for (int i = 0; i < 1000; i++) begin
      push0($urandom);
      push1($urandom);
    end
    for (int k = 0; k < 20000; k++) begin
      if (n0 - b0 >= 1000 && n1 - b1 >= 1000) break;
      rdy0 = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
      gap0 = ($urandom_range(0, 3) == 0);
      gap1 = ($urandom_range(0, 3) == 0);
      step();
    end
    gap0 = 1'b0;
    gap1 = 1'b0;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    step();
    chk("t5_num0", n0 - b0, 1000);
    chk("t5_num1", n1 - b1, 1000);
    for (int i = 0; i < 1000; i++) begin
      if (lg0_d[b0 + i] != fm0[11'(hp0 + i)])
        chk($sformatf("t5_d0_%0d", i), lg0_d[b0 + i], fm0[11'(hp0 + i)]);
      if (lg1_d[b1 + i] != fm1[11'(hp1 + i)])
        chk($sformatf("t5_d1_%0d", i), lg1_d[b1 + i], fm1[11'(hp1 + i)]);
    end
    chk("t5_order0", lg0_d[b0 + 999], fm0[11'(hp0 + 999)]);
    chk("t5_order1", lg1_d[b1 + 999], fm1[11'(hp1 + 999)]);
    chk("t5_rinc_empty0", v0, 0);
    chk("t5_rinc_empty1", v1, 0);
    chk("t5_cnt0", wc0, 1000);
    chk("t5_cnt1", wc1, 8);

    // counter wrap on u1, reset mid-packet on u0
    do_reset();
    b0 = n0;
    for (int i = 0; i < 18; i++) push1(32'(700 + i));
    push0(32'd500);
    push0(32'd501);
    steps(8);
    rdy0 = 1'b0;
    push0(32'd502);
    steps(25);
    chk("t6_wrap_cnt1", wc1, 2);
    chk("t6_pre_num0", n0 - b0, 2);
    chk("t6_pre_cnt0", wc0, 2);
    @(negedge rclk);
    chk("t6_pre_valid0", f0.m_valid, 1);
    chk("t6_pre_data0", f0.m_data, 502);
    chk("t6_pre_last0", f0.m_last, 0);
    rrst = 1'b1;
    #1;
    chk("t6_rst_valid0", f0.m_valid, 0);
    chk("t6_rst_data0", f0.m_data, 0);
    chk("t6_rst_last0", f0.m_last, 0);
    chk("t6_rst_cnt0", wc0, 0);
    chk("t6_rst_rinc0", f0.rinc, 0);
    chk("t6_rst_cnt1", wc1, 0);
    steps(2);
    rrst = 1'b0;
    step();
    b0 = n0;
    rdy0 = 1'b1;
    for (int i = 0; i < 4; i++) push0(32'(600 + i));
    steps(10);
    chk("t6_post_num0", n0 - b0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_post_d0_%0d", i), lg0_d[b0 + i], 600 + i);
      chk($sformatf("t6_post_l0_%0d", i), lg0_l[b0 + i], (i == 3) ? 1 : 0);
    end
    chk("t6_post_cnt0", wc0, 4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
